alu_arbiter_16: RTL
===================

Name: alu_arbiter_16

Overview:
- Shares one 16-bit ALU (ADD/SUB/MUL/DIV/MOD, 5-bit func) between NREQ requesters, e.g. the execute stage, address generation and a debug port.
- Round-robin arbitration with a valid/ready handshake on each request port.
- One registered response slot, tagged with the requester ID.
- Sits between the GPP16 control/issue logic and the ALU instance it owns.

Parameters:
- NREQ, 2, number of requesters, 2..8.
- IDW, $clog2(NREQ) (minimum 1), width of the requester ID tag.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle; at most one bit high.
- req_a  input  NREQ*16  operand A; requester i occupies bits [16i+15:16i].
- req_b  input  NREQ*16  operand B, same packing as req_a.
- req_func  input  NREQ*5  ALU function; requester i occupies bits [5i+4:5i].
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_y  output  16  ALU result.
- busy  output  1  equals rsp_valid; provided for the stall logic.

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, req_ready=0. Operand registers are cleared to 0 with func=ADD, so rsp_y=0. Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- Slot free condition: free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Search for the first i with req_valid[i]=1, starting at (last+1) mod NREQ and wrapping.
  - If free and such an i exists, req_ready is one-hot at i.
  - If not free, req_ready = 0.
- Accept (rising edge with req_ready[i]=1):
  - Capture req_a/b/func slice i into the operand registers.
  - rsp_id <= i; last <= i; rsp_valid <= 1.
- Latency: result is valid one cycle after accept.
  - rsp_y is the ALU output driven from the held operand registers, not from the live inputs.
  - rsp_y stays stable while rsp_valid=1 && rsp_ready=0.
- Response retire: rsp_valid && rsp_ready with no accept in the same cycle sets rsp_valid <= 0. rsp_id and the operand registers hold their values.
- Simultaneous retire and accept: the new request is loaded and rsp_valid stays 1. Back-to-back throughput is one operation per cycle.
- Backpressure: while the slot is full and rsp_ready=0, no grant is issued and last is frozen.
- Request rule: a requester holds req_valid and its operands stable until it sees req_ready. Dropping req_valid before the grant is permitted (withdrawal); the arbiter keeps no memory of it.
- Fairness: with all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Pointer wrap: last=NREQ-1 wraps the search start to 0.
- Divide/modulo by zero: the ALU returns 0. The arbiter passes this through with no error flag.
- Unsupported func values (5..31): rsp_y=0.
- Reset mid-operation: any held response is discarded and the pointer returns to NREQ-1. No req_ready is asserted while rst=1.
- Grant state is kept as a registered pointer plus a combinational rotate-priority encoder. No other FSM state exists beyond the slot bit EMPTY/FULL (= rsp_valid).

Decomposition:
- Shared package gpp16_pkg:
  - alu_func_t, a 5-bit enum: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4.
  - Constant WORD_W=16.
  - Typedef alu_req_t, a struct {a, b, func}.
- Sub-modules:
  - rr_arbiter: parameter N, inputs req/last/en, output one-hot gnt. It is natural and reusable for the memory-port arbiter.
  - The existing alu_16 is instantiated once inside for the datapath.

Test Plan:
- Reset then idle: rst pulse mid-cycle, all req_valid=0 -> rsp_valid=0, req_ready=0, rsp_y=0, busy=0.
- Single request: requester 1 sends a=7, b=5, func=MUL, rsp_ready=1 -> req_ready=2'b10 the same cycle; next cycle rsp_valid=1, rsp_id=1, rsp_y=35.
- Contention and rotation: NREQ=2, both valid continuously. Req0 is ADD 3+4, req1 is SUB 10-12, rsp_ready=1 -> grants go 0,1,0,1. Responses alternate: id0 y=7, then id1 y=0xFFFE.
- Backpressure: a response is held with rsp_ready=0 for 4 cycles while req0 is valid -> req_ready=0 and rsp_y/rsp_id stable throughout. When rsp_ready rises, req0 is accepted in that same cycle and rsp_valid stays 1.
- Divide by zero and unsupported func: DIV 100/0 -> y=0. MOD 100%7 -> y=2. func=9 -> y=0.
- Reset during full slot: response pending with rsp_ready=0, assert rst asynchronously -> rsp_valid drops immediately. After release, requester 0 wins first when both are valid.

Source files
------------

// File: rtl/gpp16_pkg.sv
// Shared GPP16 datapath types: ALU function codes, word width and request bundle.
// Also carries the response-slot state used by the ALU arbiter.
package gpp16_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [4:0] {
    ADD = 5'd0,
    SUB = 5'd1,
    MUL = 5'd2,
    DIV = 5'd3,
    MOD = 5'd4
  } alu_func_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    alu_func_t         func;
  } alu_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_arbiter_16_if.sv
// Request/response bundle between GPP16 requesters and the shared ALU arbiter.
// Requesters (and the bench) use master; the arbiter uses slave.
interface alu_arbiter_16_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ*5-1:0]  req_func;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_y;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, busy
  );
endinterface

// File: rtl/alu_16.sv
// 16-bit integer ALU: ADD/SUB/MUL (low half)/DIV/MOD, unsigned.
// Division or modulo by zero and unknown function codes yield 0.
module alu_16
  import gpp16_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  alu_func_t         func_i,
  output logic [WORD_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (func_i)
      ADD: y_o = a_i + b_i;
      SUB: y_o = a_i - b_i;
      MUL: y_o = a_i * b_i;
      DIV: if (b_i != '0) y_o = a_i / b_i;
      MOD: if (b_i != '0) y_o = a_i % b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_16_rr.sv
// Round-robin grant: first requester after last_i (wrapping) wins, one-hot.
// Reusable for any N-port arbiter; en_i gates every grant off.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last_i) + k) % N);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter_16.sv
// Shares one alu_16 between NREQ requesters with round-robin arbitration
// and a single registered, ID-tagged response slot.
module alu_arbiter_16
  import gpp16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic             clk,
  input logic             rst,
  alu_arbiter_16_if.slave bus
);

  slot_state_t       slot_q, slot_d;
  alu_req_t          op_q, op_d;
  logic [IDW-1:0]    last_q, id_q, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic              free, accept;
  logic [WORD_W-1:0] y;

  assign free   = (slot_q == EMPTY) || bus.rsp_ready;
  assign accept = |gnt;

  // rst gates grants combinationally so nothing is offered during reset.
  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .en_i   (free && !rst),
    .gnt_o  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    op_d    = op_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[IDW'(i)]) begin
        gnt_idx   = IDW'(i);
        op_d.a    = bus.req_a[WORD_W*i +: WORD_W];
        op_d.b    = bus.req_b[WORD_W*i +: WORD_W];
        op_d.func = alu_func_t'(bus.req_func[5*i +: 5]);
      end
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      EMPTY:   if (accept) slot_d = FULL;
      FULL:    if (!accept && bus.rsp_ready) slot_d = EMPTY;
      default: slot_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= EMPTY;
      last_q <= IDW'(NREQ - 1);
      id_q   <= '0;
      op_q   <= '{a: '0, b: '0, func: ADD};
    end else begin
      slot_q <= slot_d;
      if (accept) begin
        op_q   <= op_d;
        id_q   <= gnt_idx;
        last_q <= gnt_idx;
      end
    end
  end

  alu_16 u_alu (
    .a_i    (op_q.a),
    .b_i    (op_q.b),
    .func_i (op_q.func),
    .y_o    (y)
  );

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (slot_q == FULL);
  assign bus.busy      = (slot_q == FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y;

endmodule
